// File: rtl/uart_axis_pkg.sv
// Shared types and constants for the 8N1 UART / AXI-Stream transceiver.
package uart_axis_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = 10;

    // Counter width able to hold 0 .. clks_per_bit-1.
    function automatic int cnt_width(input int clks_per_bit);
        return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
    endfunction

endpackage

// File: rtl/uart_axis_xcvr_if.sv
// Byte-wide AXI-Stream handshake bundle with master/slave views.
interface uart_axis_xcvr_if;
    import uart_axis_pkg::*;

    logic              tvalid;
    logic [DATA_W-1:0] tdata;
    logic              tready;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);

endinterface

// File: rtl/uart_axis_fifo.sv
// Synchronous first-word-fall-through FIFO; head is visible on rdata while !empty.
module uart_axis_fifo
    import uart_axis_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    // A push into a full FIFO is only honoured when a pop frees the slot in the same cycle.
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_axis_xcvr.sv
// Full-duplex 8N1 UART with AXI-Stream byte ports; define UART_AXIS_FIFO_EN
// to put FIFO_DEPTH-entry FIFOs on the RX output and the TX input.
module uart_axis_xcvr
    import uart_axis_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_rxd,
    uart_axis_xcvr_if.master m_axis,
    output logic            o_rxd_busy,
    uart_axis_xcvr_if.slave  s_axis,
    input  logic            i_s_axis_thold,
    output logic            o_txd,
    output logic            o_txd_busy,
    output logic            o_txd_done
);

    localparam int               CNT_W    = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(CLKS_PER_BIT - 2);

    if (CLKS_PER_BIT < 4 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("uart_axis_xcvr: CLKS_PER_BIT must be >= 4, FIFO_DEPTH a power of 2 >= 2");
    end

    // ---------------- RX: synchronizer ----------------
    logic rxd_meta;
    logic rxd_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= i_rxd;
            rxd_sync <= rxd_meta;
        end
    end

    // ---------------- RX: deserializer FSM ----------------
    uart_state_e       rx_state;
    logic [CNT_W-1:0]  rx_cnt;
    logic [2:0]        rx_idx;
    logic              rx_busy;
    logic [DATA_W-1:0] rx_shift;
    logic              rx_push;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_busy  <= 1'b0;
        end else begin
            case (rx_state)
                ST_IDLE: begin
                    rx_cnt <= '0;
                    rx_idx <= '0;
                    if (!rxd_sync) begin
                        rx_state <= ST_START;
                        rx_busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (rx_cnt == CNT_HALF) begin
                        rx_cnt <= '0;
                        // A line already back high at mid start bit is treated as noise.
                        if (!rxd_sync) begin
                            rx_state <= ST_DATA;
                        end else begin
                            rx_state <= ST_IDLE;
                            rx_busy  <= 1'b0;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (rx_cnt == CNT_LAST) begin
                        rx_cnt <= '0;
                        if (rx_idx == 3'd7) rx_state <= ST_STOP;
                        else                rx_idx   <= rx_idx + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (rx_cnt == CNT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= ST_IDLE;
                        rx_busy  <= 1'b0;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    rx_state <= ST_IDLE;
                    rx_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (rx_state == ST_DATA && rx_cnt == CNT_LAST) rx_shift <= {rxd_sync, rx_shift[DATA_W-1:1]};
    end

    // Framing errors simply never raise rx_push.
    assign rx_push    = (rx_state == ST_STOP) && (rx_cnt == CNT_LAST) && rxd_sync;
    assign o_rxd_busy = rx_busy;

    // ---------------- TX: byte source selection ----------------
    logic              tx_load;
    logic [DATA_W-1:0] tx_byte;
    uart_state_e       tx_state;

`ifdef UART_AXIS_FIFO_EN
    logic rx_full;
    logic rx_empty;
    logic tx_full;
    logic tx_empty;

    uart_axis_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_rx_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (rx_push & ~rx_full),
        .wdata (rx_shift),
        .pop   (m_axis.tready),
        .rdata (m_axis.tdata),
        .full  (rx_full),
        .empty (rx_empty)
    );
    assign m_axis.tvalid = ~rx_empty;

    uart_axis_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_tx_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (s_axis.tvalid),
        .wdata (s_axis.tdata),
        .pop   (tx_load),
        .rdata (tx_byte),
        .full  (tx_full),
        .empty (tx_empty)
    );
    assign s_axis.tready = ~tx_full;
    assign tx_load       = (tx_state == ST_IDLE) & ~tx_empty & ~i_s_axis_thold;
`else
    logic              rx_vld;
    logic [DATA_W-1:0] rx_data;
    logic              rx_take;
    logic              tx_ready;

    // A completed byte is taken only if the holding register is free or being drained.
    assign rx_take = rx_push & (~rx_vld | m_axis.tready);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                   rx_vld <= 1'b0;
        else if (rx_take)               rx_vld <= 1'b1;
        else if (rx_vld & m_axis.tready) rx_vld <= 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (rx_take) rx_data <= rx_shift;
    end

    assign m_axis.tvalid = rx_vld;
    assign m_axis.tdata  = rx_data;

    assign tx_ready      = (tx_state == ST_IDLE) & ~i_s_axis_thold;
    assign s_axis.tready = tx_ready;
    assign tx_load       = s_axis.tvalid & tx_ready;
    assign tx_byte       = s_axis.tdata;
`endif

    // ---------------- TX: serializer FSM ----------------
    logic [CNT_W-1:0]  tx_cnt;
    logic [2:0]        tx_idx;
    logic              tx_busy;
    logic              tx_done;
    logic              txd;
    logic [DATA_W-1:0] tx_shift;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            txd      <= 1'b1;
        end else begin
            // Registered one cycle early so the pulse lands on the last stop-bit cycle.
            tx_done <= (tx_state == ST_STOP) && (tx_cnt == CNT_DONE);
            case (tx_state)
                ST_IDLE: begin
                    tx_cnt <= '0;
                    tx_idx <= '0;
                    if (tx_load) begin
                        tx_state <= ST_START;
                        tx_busy  <= 1'b1;
                        txd      <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= ST_DATA;
                        txd      <= tx_shift[0];
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == 3'd7) begin
                            tx_state <= ST_STOP;
                            txd      <= 1'b1;
                        end else begin
                            tx_idx <= tx_idx + 3'd1;
                            txd    <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= ST_IDLE;
                        tx_busy  <= 1'b0;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    tx_state <= ST_IDLE;
                    tx_busy  <= 1'b0;
                    txd      <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (tx_load)                                        tx_shift <= tx_byte;
        else if (tx_state == ST_DATA && tx_cnt == CNT_LAST) tx_shift <= tx_shift >> 1;
    end

    assign o_txd      = txd;
    assign o_txd_busy = tx_busy;
    assign o_txd_done = tx_done;

endmodule

// File: tb/tb_uart_axis_xcvr.sv
// Directed self-checking bench for uart_axis_xcvr at CLKS_PER_BIT=16.
module tb_uart_axis_xcvr;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd_tb = 1'b1;
    logic       lb_txd = 1'b0;
    logic       lb_echo = 1'b0;
    logic       tb_svalid = 1'b0;
    logic [7:0] tb_sdata = 8'h00;
    logic       tb_mready = 1'b1;
    logic       thold = 1'b0;
    logic       rxd;
    logic       rxd_busy;
    logic       txd;
    logic       txd_busy;
    logic       txd_done;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] rx_log[$];
    int         done_cnt = 0;
    int         txd_low = 0;

    logic [9:0] cap_bits;
    bit         cap_ok;
    bit         hs_ok;

    always #5 clk = ~clk;

    uart_axis_xcvr_if m_if ();
    uart_axis_xcvr_if s_if ();

    assign rxd         = lb_txd ? txd : rxd_tb;
    assign m_if.tready = lb_echo ? s_if.tready : tb_mready;
    assign s_if.tvalid = lb_echo ? m_if.tvalid : tb_svalid;
    assign s_if.tdata  = lb_echo ? m_if.tdata : tb_sdata;

    uart_axis_xcvr #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_rxd          (rxd),
        .m_axis         (m_if),
        .o_rxd_busy     (rxd_busy),
        .s_axis         (s_if),
        .i_s_axis_thold (thold),
        .o_txd          (txd),
        .o_txd_busy     (txd_busy),
        .o_txd_done     (txd_done)
    );

    always @(negedge clk) begin
        if (m_if.tvalid && m_if.tready) rx_log.push_back(m_if.tdata);
        if (txd_done) done_cnt++;
        if (!txd) txd_low++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_rx(input logic [7:0] b, input int stretch);
        @(posedge clk); #1;
        rxd_tb = 1'b0;
        repeat (CPB + stretch) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rxd_tb = b[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rxd_tb = 1'b1;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic tx_send(input logic [7:0] b, output bit ok);
        ok = 1'b0;
        tb_sdata  = b;
        tb_svalid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (s_if.tready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        tb_svalid = 1'b0;
    endtask

    // Waits for a start edge on txd, then samples all ten bits at mid-bit.
    task automatic tx_capture(output logic [9:0] bits, output bit ok);
        ok   = 1'b0;
        bits = '0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!txd) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            repeat (CPB / 2) @(posedge clk);
            @(negedge clk);
            bits[0] = txd;
            for (int k = 1; k < 10; k++) begin
                repeat (CPB) @(posedge clk);
                @(negedge clk);
                bits[k] = txd;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int d0;
        int t0;
        int lat;

        // 1: reset state
        cycles(5);
        rst_n = 1'b1;
        cycles(2);
        check("rst_txd",      txd, 1);
        check("rst_m_tvalid", m_if.tvalid, 0);
        check("rst_s_tready", s_if.tready, 1);
        check("rst_rxd_busy", rxd_busy, 0);
        check("rst_txd_busy", txd_busy, 0);
        check("rst_txd_done", txd_done, 0);

        // 2: receive 0x55 with a slightly stretched start bit
        n0 = rx_log.size();
        drive_rx(8'h55, 1);
        cycles(4);
        check("rx55_count", rx_log.size() - n0, 1);
        check("rx55_data",  (rx_log.size() > n0) ? rx_log[n0] : 8'h00, 8'h55);
        check("rx55_busy",  rxd_busy, 0);
        check("rx55_tvalid_released", m_if.tvalid, 0);

        // 3: transmit 0xA3
        d0 = done_cnt;
        tx_send(8'hA3, hs_ok);
        check("txA3_handshake", hs_ok, 1);
        tx_capture(cap_bits, cap_ok);
        check("txA3_start_seen", cap_ok, 1);
        check("txA3_bits", cap_bits, 10'h346);
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            lat++;
            if (txd_done) break;
        end
        check("txA3_done_pos", lat, 7);
        cycles(4);
        check("txA3_done_once", done_cnt - d0, 1);
        check("txA3_tready",    s_if.tready, 1);
        check("txA3_busy",      txd_busy, 0);

        // 5: 4-cycle glitch on rxd
        n0 = rx_log.size();
        @(posedge clk); #1;
        rxd_tb = 1'b0;
        cycles(4);
        rxd_tb = 1'b1;
        cycles(1);
        @(negedge clk);
        check("glitch_busy_rise", rxd_busy, 1);
        cycles(10);
        check("glitch_busy_fall", rxd_busy, 0);
        cycles(20);
        check("glitch_no_byte", rx_log.size() - n0, 0);

        // 6a: thold blocks the start of a frame
        thold     = 1'b1;
        tb_sdata  = 8'h12;
        tb_svalid = 1'b1;
        t0 = txd_low;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (s_if.tready && tb_svalid) begin
                @(posedge clk); #1;
                tb_svalid = 1'b0;
            end
        end
        check("thold_no_frame", txd_low - t0, 0);
        check("thold_busy", txd_busy, 0);
`ifdef UART_AXIS_FIFO_EN
        check("thold_tready", s_if.tready, 1);
`else
        check("thold_tready", s_if.tready, 0);
`endif
        @(posedge clk); #1;
        thold = 1'b0;
        lat = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (!txd) break;
            lat++;
        end
        check("thold_release_lat_ok", (lat <= 2) ? 1 : 0, 1);
        tb_svalid = 1'b0;
        cycles(10 * CPB + 10);
        check("thold_frame_end_busy", txd_busy, 0);

        // 6b: two bytes arrive while the consumer stalls
        tb_mready = 1'b0;
        n0 = rx_log.size();
        drive_rx(8'h3C, 0);
        drive_rx(8'hC5, 0);
        cycles(5);
        check("stall_tvalid", m_if.tvalid, 1);
        check("stall_tdata",  m_if.tdata, 8'h3C);
        check("stall_no_take", rx_log.size() - n0, 0);
        tb_mready = 1'b1;
        cycles(5);
        check("stall_first", (rx_log.size() > n0) ? rx_log[n0] : 8'h00, 8'h3C);
`ifdef UART_AXIS_FIFO_EN
        check("stall_count",  rx_log.size() - n0, 2);
        check("stall_second", (rx_log.size() > n0 + 1) ? rx_log[n0 + 1] : 8'h00, 8'hC5);
`else
        check("stall_count",  rx_log.size() - n0, 1);
`endif
        check("stall_drained", m_if.tvalid, 0);

        // 4a: echo RX master into TX slave
        lb_echo = 1'b1;
        fork
            drive_rx(8'h55, 0);
            tx_capture(cap_bits, cap_ok);
        join
        check("echo_start_seen", cap_ok, 1);
        check("echo_bits", cap_bits, 10'h2AA);
        cycles(30);
        lb_echo = 1'b0;
        check("echo_tx_idle", txd_busy, 0);

        // 4b: txd looped back into rxd
        lb_txd = 1'b1;
        n0 = rx_log.size();
        tx_send(8'h5A, hs_ok);
        check("loop_handshake", hs_ok, 1);
        cycles(10 * CPB + 30);
        check("loop_count", rx_log.size() - n0, 1);
        check("loop_data",  (rx_log.size() > n0) ? rx_log[n0] : 8'h00, 8'h5A);
        lb_txd = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
